// File: rtl/fifo_burst_reader.sv
// Pulls fixed-length bursts, or single-beat flush transfers, out of a synchronous-read FIFO.
// Beats go downstream through a 2-entry skid buffer so the stream can run at one beat per clock.
module fifo_burst_reader #(
    parameter int dw = 8,
    parameter int bl = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          flush,
    input  logic [dw-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic          fifo_empty_n,
    output logic          fifo_re,
    output logic [dw-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_first,
    output logic          m_last,
    output logic          busy,
    output logic [15:0]   burst_cnt
);
    localparam int IW = $clog2(bl + 1);
    localparam logic [IW-1:0] BL_CNT  = IW'(bl);
    localparam logic [IW-1:0] BL_LAST = IW'(bl - 1);

    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_occ;
    logic          r_infl;
    logic          r_infl_first;
    logic          r_infl_last;
    logic [IW-1:0] r_issued;
    logic [dw-1:0] r_data0;
    logic [dw-1:0] r_data1;
    logic          r_first0;
    logic          r_first1;
    logic          r_last0;
    logic          r_last1;
    logic [15:0]   r_burst_cnt;

    logic          w_pop;
    logic          w_room;
    logic          w_re;
    logic          w_start;
    logic          w_first_tag;
    logic          w_last_tag;
    logic [1:0]    w_wr_idx;

    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_data0;
    assign m_first   = r_first0;
    assign m_last    = r_last0;
    assign busy      = (r_state != IDLE);
    assign burst_cnt = r_burst_cnt;

    // A new read may only be issued if its data is guaranteed a free buffer slot on return.
    assign w_pop       = m_valid & m_ready;
    assign w_room      = (r_occ == 2'd0) | ((r_occ == 2'd1) & ~r_infl) | w_pop;
    assign w_first_tag = (r_state == FLUSH) | (r_issued == '0);
    assign w_last_tag  = (r_state == FLUSH) | (r_issued == BL_LAST);
    assign w_wr_idx    = r_occ - {1'b0, w_pop};

    always_comb begin
        w_next  = r_state;
        w_re    = 1'b0;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && !fifo_empty_n) begin
                    w_next  = BURST;
                    w_start = 1'b1;
                end else if (en && flush && fifo_empty_n && !fifo_empty) begin
                    w_next = FLUSH;
                end
            end
            BURST: begin
                w_re = (r_issued < BL_CNT) && !fifo_empty && w_room;
                if ((r_issued == BL_CNT) && !r_infl) w_next = IDLE;
            end
            FLUSH: begin
                if ((fifo_empty && !r_infl) || !fifo_empty_n) w_next = IDLE;
                else w_re = !fifo_empty && w_room;
            end
            default: w_next = IDLE;
        endcase
        if (clr) begin
            w_next  = IDLE;
            w_re    = 1'b0;
            w_start = 1'b0;
        end
    end

    assign fifo_re = w_re & rst;

    // Burst beats never carry first and last together (bl >= 2), which tells them apart from flush beats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_occ        <= 2'd0;
            r_infl       <= 1'b0;
            r_infl_first <= 1'b0;
            r_infl_last  <= 1'b0;
            r_issued     <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_first0     <= 1'b0;
            r_first1     <= 1'b0;
            r_last0      <= 1'b0;
            r_last1      <= 1'b0;
            r_burst_cnt  <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_pop && r_last0 && !r_first0) r_burst_cnt <= r_burst_cnt + 16'd1;
            if (w_pop) begin
                r_data0  <= r_data1;
                r_first0 <= r_first1;
                r_last0  <= r_last1;
            end
            if (r_infl) begin
                if (w_wr_idx == 2'd0) begin
                    r_data0  <= fifo_dout;
                    r_first0 <= r_infl_first;
                    r_last0  <= r_infl_last;
                end else begin
                    r_data1  <= fifo_dout;
                    r_first1 <= r_infl_first;
                    r_last1  <= r_infl_last;
                end
            end
            if (clr) begin
                r_occ    <= 2'd0;
                r_infl   <= 1'b0;
                r_issued <= '0;
            end else begin
                r_occ  <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
                r_infl <= w_re;
                if (w_start) r_issued <= '0;
                else if (w_re && (r_state == BURST)) r_issued <= r_issued + 1'b1;
                if (w_re) begin
                    r_infl_first <= w_first_tag;
                    r_infl_last  <= w_last_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and an
// expected-beat queue built from the burst/flush rules scores every accepted output beat.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int BL = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          en;
    logic          flush;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_empty_n;
    logic          fifo_re;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic [15:0]   burst_cnt;

    fifo_burst_reader #(.dw(DW), .bl(BL)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .flush(flush),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_empty_n(fifo_empty_n),
        .fifo_re(fifo_re), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_first(m_first), .m_last(m_last), .busy(busy), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] fifoQ[$];
    beat_t         expQ[$];
    logic [15:0]   expCnt = 16'd0;
    int            cycleNo = 0;
    int            reCount = 0;
    int            popCount = 0;
    int            firstReCycle = 0;
    int            lastReCycle = 0;
    int            firstPopCycle = 0;
    int            lastPopCycle = 0;
    logic          sRe, sValid, sFirst, sLast, sBusy;
    logic [DW-1:0] sData;
    logic [15:0]   sCnt;
    logic          prevStall = 1'b0;
    beat_t         prevBeat;

    task automatic updateFlags();
        fifo_empty   = (fifoQ.size() == 0);
        fifo_empty_n = (fifoQ.size() < BL);
    endtask

    task automatic writeWord(input logic [DW-1:0] d);
        fifoQ.push_back(d);
        updateFlags();
    endtask

    // Expected tags come straight from the beat's position: first at 0, last at BL-1, flush beats both.
    task automatic expectBurstBeat(input logic [DW-1:0] d, input int idx);
        expQ.push_back(beat_t'({d, idx == 0, idx == BL - 1}));
    endtask

    task automatic expectFlushBeat(input logic [DW-1:0] d);
        expQ.push_back(beat_t'({d, 1'b1, 1'b1}));
    endtask

    task automatic clearStats();
        reCount  = 0;
        popCount = 0;
    endtask

    // One clock: sample and score at the falling edge, then serve the FIFO read after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        sRe = fifo_re; sValid = m_valid; sData = m_data; sFirst = m_first; sLast = m_last;
        sBusy = busy; sCnt = burst_cnt;
        if (sRe === 1'b1) begin
            vectors++;
            if (fifo_empty !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL empty_read: fifo_empty=%b while fifo_re=1, required 0", fifo_empty);
            end
            if (reCount == 0) firstReCycle = cycleNo;
            lastReCycle = cycleNo;
            reCount++;
        end
        if (prevStall) begin
            vectors++;
            if ({sValid, sData, sFirst, sLast} !== {1'b1, prevBeat}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got valid/beat %b/%h, required 1/%h", sValid, {sData, sFirst, sLast}, prevBeat);
            end
        end
        if (sValid && m_ready) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_beat: got data/first/last %h/%b/%b, required no beat", sData, sFirst, sLast);
            end else begin
                e = expQ.pop_front();
                if ({sData, sFirst, sLast} !== e) begin
                    miscompares++;
                    $display("[TB] FAIL beat: got data/first/last %h/%b/%b, required %h/%b/%b", sData, sFirst, sLast, e.data, e.first, e.last);
                end
            end
            if (popCount == 0) firstPopCycle = cycleNo;
            lastPopCycle = cycleNo;
            popCount++;
        end
        prevStall = sValid && !m_ready;
        prevBeat  = beat_t'({sData, sFirst, sLast});
        @(posedge clk);
        #1;
        if (sRe === 1'b1 && fifoQ.size() > 0) fifo_dout = fifoQ.pop_front();
        updateFlags();
        cycleNo++;
    endtask

    task automatic waitIdle(input int budget, input string name, input bit randReady);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            if (randReady) m_ready = 1'($urandom_range(0, 1));
            tick();
            done = !sBusy && !sValid && (expQ.size() == 0) && (fifoQ.size() == 0);
        end
        m_ready = 1'b1;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: %0d beats still expected after %0d clocks, required 0", name, expQ.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b1; fifo_dout = '0;
        updateFlags();
        repeat (3) tick();
        vectors += 7;
        if (sValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b, required 0", sValid); end
        if (sData !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data: got %h, required 00", sData); end
        if (sFirst !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_first: got %b, required 0", sFirst); end
        if (sLast !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_last: got %b, required 0", sLast); end
        if (sBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b, required 0", sBusy); end
        if (sCnt !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_cnt: got %h, required 0000", sCnt); end
        if (sRe !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_re: got %b, required 0", sRe); end
        for (int i = 0; i < BL; i++) writeWord(8'hE0 + 8'(i));
        en = 1'b1;
        repeat (2) begin
            tick();
            vectors++;
            if ({sRe, sBusy} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_hold: got re/busy %b/%b, required 0/0", sRe, sBusy); end
        end
        en = 1'b0;
        fifoQ.delete();
        updateFlags();
        rst = 1'b1;
        tick();
        prevStall = 1'b0;
    endtask

    task automatic test_basic_burst();
        for (int i = 0; i < BL; i++) begin
            writeWord(8'h10 + 8'(i));
            expectBurstBeat(8'h10 + 8'(i), i);
        end
        clearStats();
        en = 1'b1; m_ready = 1'b1;
        waitIdle(40, "basic", 1'b0);
        expCnt++;
        vectors += 5;
        if (reCount !== BL) begin miscompares++; $display("[TB] FAIL basic_re_count: got %0d, required %0d", reCount, BL); end
        if (lastReCycle - firstReCycle !== BL - 1) begin miscompares++; $display("[TB] FAIL basic_re_span: got %0d, required %0d", lastReCycle - firstReCycle, BL - 1); end
        if (popCount !== BL) begin miscompares++; $display("[TB] FAIL basic_pop_count: got %0d, required %0d", popCount, BL); end
        if (lastPopCycle - firstPopCycle !== BL - 1) begin miscompares++; $display("[TB] FAIL basic_pop_span: got %0d, required %0d", lastPopCycle - firstPopCycle, BL - 1); end
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL basic_cnt: got %h, required %h", sCnt, expCnt); end
        en = 1'b0;
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        for (int i = 0; i < BL; i++) begin
            writeWord(8'h10 + 8'(i));
            expectBurstBeat(8'h10 + 8'(i), i);
        end
        clearStats();
        m_ready = 1'b0; en = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            seen = sValid;
        end
        repeat (5) tick();
        vectors += 2;
        if (!seen) begin miscompares++; $display("[TB] FAIL bp_first_valid: got no valid in 10 clocks, required valid"); end
        if (reCount !== 2) begin miscompares++; $display("[TB] FAIL bp_outstanding: got %0d reads while stalled, required 2", reCount); end
        m_ready = 1'b1;
        waitIdle(40, "bp", 1'b0);
        expCnt++;
        vectors += 2;
        if (reCount !== BL) begin miscompares++; $display("[TB] FAIL bp_re_count: got %0d, required %0d", reCount, BL); end
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL bp_cnt: got %h, required %h", sCnt, expCnt); end
        en = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            writeWord(8'hA0 + 8'(i));
            expectFlushBeat(8'hA0 + 8'(i));
        end
        clearStats();
        en = 1'b1; flush = 1'b1; m_ready = 1'b1;
        waitIdle(40, "flush", 1'b0);
        vectors += 2;
        if (reCount !== 3) begin miscompares++; $display("[TB] FAIL flush_re_count: got %0d, required 3", reCount); end
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL flush_cnt: got %h, required %h", sCnt, expCnt); end
        en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_sub_burst();
        bit started = 1'b0;
        for (int i = 0; i < BL - 1; i++) begin
            writeWord(8'h30 + 8'(i));
            expectBurstBeat(8'h30 + 8'(i), i);
        end
        clearStats();
        en = 1'b1; m_ready = 1'b1;
        repeat (5) begin
            tick();
            vectors++;
            if ({sRe, sBusy} !== 2'b00) begin miscompares++; $display("[TB] FAIL sub_idle: got re/busy %b/%b, required 0/0", sRe, sBusy); end
        end
        writeWord(8'h30 + 8'(BL - 1));
        expectBurstBeat(8'h30 + 8'(BL - 1), BL - 1);
        for (int n = 0; n < 2 && !started; n++) begin
            tick();
            started = sBusy && sRe;
        end
        vectors++;
        if (!started) begin miscompares++; $display("[TB] FAIL sub_start: got no burst within 2 clocks of 4th word, required start"); end
        waitIdle(40, "sub", 1'b0);
        expCnt++;
        vectors++;
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL sub_cnt: got %h, required %h", sCnt, expCnt); end
        en = 1'b0;
    endtask

    // Abort (clr or reset) after two reads issued; only the first beat, already buffered, may go out.
    task automatic test_abort(input bit useReset);
        bit reached = 1'b0;
        for (int i = 0; i < BL; i++) writeWord(8'h50 + 8'(i));
        expectBurstBeat(8'h50, 0);
        clearStats();
        en = 1'b1; m_ready = 1'b1;
        for (int n = 0; n < 10 && !reached; n++) begin
            tick();
            reached = (reCount >= 2);
        end
        if (useReset) rst = 1'b0; else clr = 1'b1;
        tick();
        vectors += 2;
        if (!reached) begin miscompares++; $display("[TB] FAIL abort_setup: got %0d reads, required 2", reCount); end
        if (sRe !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_re_cycle: got %b, required 0", sRe); end
        rst = 1'b1; clr = 1'b0; en = 1'b0;
        if (useReset) expCnt = 16'd0;
        tick();
        vectors += 4;
        if (sValid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_valid: got %b, required 0", sValid); end
        if (sBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b, required 0", sBusy); end
        if (sRe !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_re: got %b, required 0", sRe); end
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL abort_cnt: got %h, required %h", sCnt, expCnt); end
        repeat (4) tick();
        vectors++;
        if (expQ.size() !== 0) begin miscompares++; $display("[TB] FAIL abort_first_beat: got %0d beats unsent, required 0", expQ.size()); end
        fifoQ.delete();
        updateFlags();
        prevStall = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int remaining, chunk, idx, k;
        en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, BL - 1);
                for (int i = 0; i < k; i++) begin
                    d = 8'($urandom());
                    writeWord(d);
                    expectFlushBeat(d);
                end
                repeat (2) tick();
                flush = 1'b1;
                waitIdle(100, "rand_flush", 1'b1);
                flush = 1'b0;
            end else begin
                remaining = BL; idx = 0;
                while (remaining > 0) begin
                    chunk = $urandom_range(1, remaining);
                    for (int i = 0; i < chunk; i++) begin
                        d = 8'($urandom());
                        writeWord(d);
                        expectBurstBeat(d, idx);
                        idx++;
                    end
                    remaining -= chunk;
                    repeat ($urandom_range(1, 3)) begin
                        m_ready = 1'($urandom_range(0, 1));
                        tick();
                    end
                end
                waitIdle(200, "rand_burst", 1'b1);
                expCnt++;
            end
            vectors++;
            if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL rand_cnt: got %h, required %h", sCnt, expCnt); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        force dut.r_burst_cnt = 16'hFFFE;
        tick();
        release dut.r_burst_cnt;
        tick();
        expCnt = 16'hFFFE;
        vectors++;
        if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL wrap_preset: got %h, required %h", sCnt, expCnt); end
        en = 1'b1; m_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < BL; i++) begin
                writeWord(8'h70 + 8'(i));
                expectBurstBeat(8'h70 + 8'(i), i);
            end
            waitIdle(40, "wrap", 1'b0);
            expCnt++;
            vectors++;
            if (sCnt !== expCnt) begin miscompares++; $display("[TB] FAIL wrap_cnt: got %h, required %h", sCnt, expCnt); end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_flush();
        test_sub_burst();
        test_abort(1'b0);
        test_random();
        test_abort(1'b1);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter dw, default 8, data width.
REQ-002 SHALL have parameter bl, default 4, beats per burst (2..255).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous abort.
REQ-006 SHALL have port en, input, 1, enables new bursts.
REQ-007 SHALL have port flush, input, 1, drains a partial FIFO as single-beat transfers.
REQ-008 SHALL have port fifo_dout, input, dw, FIFO read data.
REQ-009 SHALL have port fifo_empty, input, 1, combinational FIFO empty flag.
REQ-010 SHALL have port fifo_empty_n, input, 1, FIFO holds fewer than bl words (FIFO n = bl).
REQ-011 SHALL have port fifo_re, output, 1, FIFO read strobe.
REQ-012 SHALL have ports m_data (output, dw), m_valid (output, 1) and m_ready (input, 1), forming the output stream.
REQ-013 SHALL have ports m_first and m_last, both output, 1, burst boundary markers.
REQ-014 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-015 SHALL have port burst_cnt, output, 16, completed full bursts, wrapping.

Function
REQ-016 SHALL present FIFO data on fifo_dout one clk after the fifo_re cycle; one read is in flight per fifo_re.
REQ-017 SHALL buffer output in a 2-entry FIFO-ordered skid buffer.
- occ = 0..2 entries
- infl = 0..1 reads in flight
REQ-018 SHALL assert fifo_re only when all of the following hold:
- state is BURST or FLUSH
- !fifo_empty
- in BURST, issued < bl
- (occ + infl <= 1) or pop, where pop = m_valid & m_ready
REQ-019 SHALL never assert fifo_re while fifo_empty = 1.
REQ-020 SHALL hold m_valid = (occ != 0), with m_data/m_first/m_last taken from the buffer head; these SHALL be stable while m_valid & !m_ready.
REQ-021 SHALL use the states IDLE, BURST and FLUSH with these transitions:
- IDLE->BURST when en & !fifo_empty_n; issued cleared to 0
- IDLE->FLUSH when en & flush & fifo_empty_n & !fifo_empty
- BURST priority over FLUSH
REQ-022 SHALL return BURST->IDLE when issued = bl and infl = 0; en falling mid-burst SHALL NOT truncate the burst.
REQ-023 SHALL return FLUSH->IDLE when fifo_empty & infl = 0, or when !fifo_empty_n (a full burst becomes available); no read SHALL be issued in the exit cycle.
REQ-024 SHALL tag beats in BURST as follows: beat 0 has m_first = 1, beat bl-1 has m_last = 1, all other beats have both 0.
REQ-025 SHALL tag every beat in FLUSH with m_first = m_last = 1.
REQ-026 SHALL increment burst_cnt by 1 when the m_last beat of a BURST transfer pops, with 16'hFFFF -> 0 wrap; FLUSH beats SHALL NOT count.
REQ-027 SHALL allow push and pop in the same cycle with occ unchanged; returned data SHALL never be dropped when occ = 2 (guaranteed by REQ-018).
REQ-028 SHALL, on clr = 1, go to IDLE next clk and apply the following:
- occ = 0, infl = 0, issued = 0
- in-flight data discarded
- fifo_re = 0 in the clr cycle
- burst_cnt retained
REQ-029 SHALL give clr priority over all other inputs; rst SHALL take priority over clr.
REQ-030 SHALL reach a sustained throughput of 1 beat/clk when m_ready = 1 and the FIFO has data.

Reset
REQ-031 SHALL, when rst = 0 at a clk edge, set the following:
- state IDLE; occ = 0, infl = 0, issued = 0
- m_valid = 0, m_data = 0, m_first = 0, m_last = 0
- busy = 0, burst_cnt = 0
- fifo_re = 0 combinationally while rst = 0
REQ-032 SHALL, on reset mid-burst, discard all partial-burst state, with no m_last emitted afterwards.

Verification (dw = 8, bl = 4)
REQ-033 SHALL cover the basic burst: FIFO preloaded with 0x10..0x13, en = 1, m_ready = 1 -> fifo_re high 4 consecutive clks, m_data 10,11,12,13 on consecutive clks, first on 10, last on 13, burst_cnt = 1.
REQ-034 SHALL cover backpressure: same stimulus with m_ready = 0 for 5 clks after the first valid -> fifo_re stops after 2 outstanding words, no data lost, order 10..13, m_data stable while stalled.
REQ-035 SHALL cover flush: 3 words (0xA0..0xA2), en = flush = 1 -> 3 single-beat transfers each with first = last = 1, then IDLE, burst_cnt unchanged.
REQ-036 SHALL cover a sub-burst with no flush: 3 words, en = 1, flush = 0 -> no fifo_re, busy = 0; a 4th write -> burst starts within 2 clks.
REQ-037 SHALL cover clr mid-burst: clr after 2 beats issued -> next clk m_valid = 0, busy = 0, fifo_re = 0, no m_last seen.
REQ-038 SHALL cover counter wrap: burst_cnt forced near 16'hFFFF, 2 bursts -> 16'hFFFF then 0; empty-read assertion never fires.
